rr_bus_scheduler: RTL and testbench

RR_BUS_SCHEDULER -- requirements
Module: rr_bus_scheduler

---
 rtl/rr_bus_scheduler.sv | 138 +++++++++++++
 tb/tb_rr_bus_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_scheduler.sv
// Round-robin bus scheduler: grants one master at a time, watches the shared
// utilisation line for bus start/release, and aborts stalled or overlong owners.
module rr_bus_scheduler #(
  parameter int N_MASTERS    = 12,
  parameter int TIMEOUT_LEN  = 6,
  parameter int OWN_LEN      = 10,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] m_reqs,
  input  logic                 bus_util,
  output logic [N_MASTERS-1:0] m_grants,
  output logic [3:0]           mid_current,
  output logic [3:0]           state,
  output logic                 timeout,
  output logic [7:0]           err_cnt
);

  localparam int CNT_MAX_W = (OWN_LEN > TIMEOUT_LEN) ? OWN_LEN : TIMEOUT_LEN;
  localparam int CNT_W     = (CNT_MAX_W > 3) ? CNT_MAX_W : 3;
  localparam logic [CNT_W-1:0] START_MAX  = CNT_W'((64'd1 << TIMEOUT_LEN) - 64'd1);
  localparam logic [CNT_W-1:0] OWN_MAX    = CNT_W'((64'd1 << OWN_LEN) - 64'd1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WAIT_START = 4'd1,
    S_OWNED      = 4'd2,
    S_GUARD      = 4'd3
  } state_t;

  state_t               r_state;
  logic [N_MASTERS-1:0] r_grants;
  logic [3:0]           r_mid;
  logic [3:0]           r_last;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_timeout;
  logic [7:0]           r_err;

  logic [N_MASTERS-1:0] w_hi_mask;
  logic [N_MASTERS-1:0] w_hi_reqs;
  logic [N_MASTERS-1:0] w_pool;
  logic [3:0]           w_winner;
  logic                 w_grantee_req;

  // Rotating priority: lowest requester above the last winner, else lowest overall.
  always_comb begin
    w_hi_mask = ~((N_MASTERS'(2) << r_last) - N_MASTERS'(1));
    w_hi_reqs = m_reqs & w_hi_mask;
    w_pool    = (|w_hi_reqs) ? w_hi_reqs : m_reqs;
    w_winner  = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (w_pool[i]) w_winner = 4'(i);
    end
  end

  assign w_grantee_req = |(m_reqs & r_grants);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grants  <= '0;
      r_mid     <= '0;
      r_last    <= 4'(N_MASTERS - 1);
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_err     <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if ((|m_reqs) && bus_util) begin
            r_state  <= S_WAIT_START;
            r_grants <= N_MASTERS'(1) << w_winner;
            r_mid    <= w_winner;
            r_last   <= w_winner;
            r_cnt    <= '0;
          end
        end
        S_WAIT_START: begin
          if (!bus_util) begin
            r_state <= S_OWNED;
            r_cnt   <= '0;
          end else if (!w_grantee_req) begin
            r_state  <= S_GUARD;
            r_grants <= '0;
            r_cnt    <= '0;
          end else if (r_cnt == START_MAX) begin
            r_state   <= S_GUARD;
            r_grants  <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b1;
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_OWNED: begin
          // A dropped request is ignored here; only the line or the watchdog ends ownership.
          if (bus_util) begin
            r_state  <= S_GUARD;
            r_grants <= '0;
            r_cnt    <= '0;
          end else if (r_cnt == OWN_MAX) begin
            r_state   <= S_GUARD;
            r_grants  <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b1;
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GUARD: begin
          if (r_cnt == GUARD_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_grants <= '0;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign m_grants    = r_grants;
  assign mid_current = r_mid;
  assign state       = r_state;
  assign timeout     = r_timeout;
  assign err_cnt     = r_err;

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Self-checking bench for rr_bus_scheduler: directed scenarios plus randomized
// transactions compared against a round-robin reference model.
module tb_rr_bus_scheduler;

  localparam int N     = 12;
  localparam int GUARD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_util = 1'b1;
  logic [11:0] m_reqs = '0;
  logic [11:0] m_grants;
  logic [3:0]  mid_current;
  logic [3:0]  state;
  logic        timeout;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rr_bus_scheduler #(
    .N_MASTERS(N), .TIMEOUT_LEN(6), .OWN_LEN(10), .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .m_reqs(m_reqs), .bus_util(bus_util),
    .m_grants(m_grants), .mid_current(mid_current), .state(state),
    .timeout(timeout), .err_cnt(err_cnt)
  );

  // Reference rule: scan ids last+1, last+2, ... modulo N, first requester wins.
  function automatic int rr_pick(input logic [11:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      int id;
      id = (last + k) % N;
      if (mask[id]) return id;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; m_reqs = '0; bus_util = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for a nonzero grant; zeros = negedges seen with no grant.
  task automatic grant_wait(output logic [11:0] g, output int zeros);
    zeros = 0;
    while (m_grants == '0 && zeros < 200) begin
      zeros++;
      @(negedge clk);
    end
    g = m_grants;
  endtask

  task automatic hold_count(output int hi, input int limit);
    hi = 0;
    while (m_grants != '0 && hi < limit) begin
      hi++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_reqs = 12'hFFF; bus_util = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (m_grants !== 12'h000) $display("FAIL reset_grants: got %h, expected 000", m_grants); else n_pass++;
    n_checks++; if (state !== 4'd0) $display("FAIL reset_state: got %0d, expected 0", state); else n_pass++;
    n_checks++; if (mid_current !== 4'd0) $display("FAIL reset_mid: got %0d, expected 0", mid_current); else n_pass++;
    n_checks++; if ({timeout, err_cnt} !== 9'd0) $display("FAIL reset_err: got to=%b err=%0d, expected 0/0", timeout, err_cnt); else n_pass++;
    m_reqs = '0; bus_util = 1'b1; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rr_order();
    int order [4] = '{0, 3, 0, 3};
    logic [11:0] g, oh;
    int zeros;
    do_reset();
    m_reqs = 12'h009;
    for (int j = 0; j < 4; j++) begin
      grant_wait(g, zeros);
      oh = 12'b1 << order[j];
      n_checks++; if (g !== oh) $display("FAIL rr_order_grant j=%0d: got %h, expected %h", j, g, oh); else n_pass++;
      if (j > 0) begin
        n_checks++; if (zeros !== GUARD + 1) $display("FAIL rr_order_gap j=%0d: got %0d, expected %0d", j, zeros, GUARD + 1); else n_pass++;
      end
      bus_util = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (state !== 4'd2 || m_grants !== oh) $display("FAIL rr_order_owned j=%0d: got st=%0d g=%h, expected 2/%h", j, state, m_grants, oh); else n_pass++;
      bus_util = 1'b1;
      @(negedge clk);
      n_checks++; if (m_grants !== 12'h000 || timeout !== 1'b0) $display("FAIL rr_order_release j=%0d: got g=%h to=%b, expected 000/0", j, m_grants, timeout); else n_pass++;
    end
    m_reqs = '0;
  endtask

  task automatic test_start_timeout();
    logic [11:0] g;
    int zeros, hi;
    do_reset();
    m_reqs = 12'h800;
    grant_wait(g, zeros);
    n_checks++; if (g !== 12'h800 || mid_current !== 4'd11) $display("FAIL st_grant: got g=%h mid=%0d, expected 800/11", g, mid_current); else n_pass++;
    hold_count(hi, 300);
    n_checks++; if (hi !== 64) $display("FAIL st_len: got %0d cycles, expected 64", hi); else n_pass++;
    n_checks++; if (timeout !== 1'b1 || err_cnt !== 8'd1) $display("FAIL st_abort: got to=%b err=%0d, expected 1/1", timeout, err_cnt); else n_pass++;
    n_checks++; if (state !== 4'd3 || mid_current !== 4'd11) $display("FAIL st_guard: got st=%0d mid=%0d, expected 3/11", state, mid_current); else n_pass++;
    @(negedge clk);
    n_checks++; if (timeout !== 1'b0) $display("FAIL st_pulse: got %b, expected 0", timeout); else n_pass++;
    grant_wait(g, zeros);
    n_checks++; if (g !== 12'h800 || zeros !== GUARD) $display("FAIL st_regrant: got g=%h gap=%0d, expected 800/%0d", g, zeros, GUARD); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [11:0] g;
    int zeros;
    m_reqs = 12'h004;
    @(negedge clk);
    grant_wait(g, zeros);
    n_checks++; if (g !== 12'h004 || mid_current !== 4'd2) $display("FAIL rm_grant: got g=%h mid=%0d, expected 004/2", g, mid_current); else n_pass++;
    n_checks++; if (zeros !== GUARD + 1 || err_cnt !== 8'd1) $display("FAIL rm_drop: got gap=%0d err=%0d, expected %0d/1", zeros, err_cnt, GUARD + 1); else n_pass++;
    bus_util = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (state !== 4'd2) $display("FAIL rm_owned: got %0d, expected 2", state); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (m_grants !== 12'h000 || state !== 4'd0 || mid_current !== 4'd0) $display("FAIL rm_reset: got g=%h st=%0d mid=%0d, expected 000/0/0", m_grants, state, mid_current); else n_pass++;
    n_checks++; if (err_cnt !== 8'd0 || timeout !== 1'b0) $display("FAIL rm_reset_err: got err=%0d to=%b, expected 0/0", err_cnt, timeout); else n_pass++;
    rst = 1'b0; bus_util = 1'b1;
    @(negedge clk);
    n_checks++; if (m_grants !== 12'h004) $display("FAIL rm_after: got %h, expected 004", m_grants); else n_pass++;
    m_reqs = '0;
  endtask

  task automatic test_own_timeout();
    logic [11:0] g;
    int zeros, hi;
    do_reset();
    m_reqs = 12'h010;
    grant_wait(g, zeros);
    n_checks++; if (g !== 12'h010) $display("FAIL ot_grant: got %h, expected 010", g); else n_pass++;
    bus_util = 1'b0;
    @(negedge clk);
    hold_count(hi, 1200);
    n_checks++; if (hi !== 1024) $display("FAIL ot_len: got %0d cycles, expected 1024", hi); else n_pass++;
    n_checks++; if (timeout !== 1'b1 || err_cnt !== 8'd1 || state !== 4'd3) $display("FAIL ot_abort: got to=%b err=%0d st=%0d, expected 1/1/3", timeout, err_cnt, state); else n_pass++;
    repeat (75) @(negedge clk);
    n_checks++; if (m_grants !== 12'h000 || state !== 4'd0) $display("FAIL ot_blocked: got g=%h st=%0d, expected 000/0", m_grants, state); else n_pass++;
    bus_util = 1'b1;
    @(negedge clk);
    n_checks++; if (m_grants !== 12'h010) $display("FAIL ot_unblock: got %h, expected 010", m_grants); else n_pass++;
  endtask

  task automatic test_drop_in_wait();
    logic [11:0] g;
    int zeros;
    m_reqs = 12'h020;
    @(negedge clk);
    grant_wait(g, zeros);
    n_checks++; if (g !== 12'h020) $display("FAIL dw_grant: got %h, expected 020", g); else n_pass++;
    repeat (2) @(negedge clk);
    m_reqs = '0;
    @(negedge clk);
    n_checks++; if (m_grants !== 12'h000 || state !== 4'd3 || timeout !== 1'b0) $display("FAIL dw_guard: got g=%h st=%0d to=%b, expected 000/3/0", m_grants, state, timeout); else n_pass++;
    @(negedge clk);
    n_checks++; if (err_cnt !== 8'd1 || timeout !== 1'b0) $display("FAIL dw_err: got err=%0d to=%b, expected 1/0", err_cnt, timeout); else n_pass++;
  endtask

  task automatic test_err_saturate();
    logic [11:0] g;
    int zeros, hi;
    bit stalled;
    do_reset();
    m_reqs = 12'h001;
    stalled = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      grant_wait(g, zeros);
      hold_count(hi, 100);
      if (g == '0 || hi >= 100) begin
        stalled = 1'b1;
        break;
      end
      if (i == 1 || i == 254) begin
        n_checks++; if (err_cnt !== 8'(i)) $display("FAIL sat_count i=%0d: got %0d, expected %0d", i, err_cnt, i); else n_pass++;
      end
      if (i == 255 || i == 260) begin
        n_checks++; if (err_cnt !== 8'd255) $display("FAIL sat_hold i=%0d: got %0d, expected 255", i, err_cnt); else n_pass++;
      end
    end
    n_checks++; if (stalled) $display("FAIL sat_progress: got stalled=1, expected 0"); else n_pass++;
    m_reqs = '0;
  endtask

  task automatic test_random();
    logic [11:0] mask, g, oh;
    logic [7:0]  err0;
    int exp_last, exp_id, zeros, k, d, mode;
    do_reset();
    exp_last = N - 1;
    for (int t = 0; t < 40; t++) begin
      mask = 12'($urandom_range(1, 4095));
      m_reqs = mask; bus_util = 1'b1;
      grant_wait(g, zeros);
      exp_id = rr_pick(mask, exp_last);
      oh = 12'b1 << exp_id;
      n_checks++; if (g !== oh || mid_current !== 4'(exp_id)) $display("FAIL rand_grant t=%0d mask=%h: got g=%h mid=%0d, expected %h/%0d", t, mask, g, mid_current, oh, exp_id); else n_pass++;
      if (t > 0) begin
        n_checks++; if (zeros !== GUARD + 1) $display("FAIL rand_gap t=%0d: got %0d, expected %0d", t, zeros, GUARD + 1); else n_pass++;
      end
      exp_last = exp_id;
      err0 = err_cnt;
      mode = $urandom_range(0, 1);
      k = $urandom_range(0, 4);
      repeat (k) @(negedge clk);
      if (mode == 0) begin
        bus_util = 1'b0;
        m_reqs = 12'($urandom);
        d = $urandom_range(1, 6);
        repeat (d) @(negedge clk);
        n_checks++; if (m_grants !== oh || state !== 4'd2) $display("FAIL rand_owned t=%0d: got g=%h st=%0d, expected %h/2", t, m_grants, state, oh); else n_pass++;
        bus_util = 1'b1;
      end else begin
        m_reqs = mask & ~oh;
      end
      @(negedge clk);
      n_checks++; if (m_grants !== 12'h000 || state !== 4'd3 || timeout !== 1'b0) $display("FAIL rand_end t=%0d: got g=%h st=%0d to=%b, expected 000/3/0", t, m_grants, state, timeout); else n_pass++;
      n_checks++; if (err_cnt !== err0) $display("FAIL rand_err t=%0d: got %0d, expected %0d", t, err_cnt, err0); else n_pass++;
    end
    m_reqs = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_order();
    test_start_timeout();
    test_reset_mid();
    test_own_timeout();
    test_drop_in_wait();
    test_random();
    test_err_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
